// File: rtl/path_replay_ctrl.sv
// -----------------------------------------------------------------------------
// path_replay_ctrl
//   Sits between the path generator and the pricing engine. It captures
//   NPATH x DAY generated samples into an internal buffer, then replays the
//   whole buffer to the pricing engine as one gap-free stream. Every
//   start_replay / resend request restarts that stream from sample 0.
//
// Ports
//   clk           clock, all logic on the rising edge
//   rst_n         asynchronous active-low reset
//   clear         synchronous abort: back to IDLE, counters zeroed, full dropped
//   wr_valid      path-generator sample strobe
//   wr_data       path-generator sample (W bits)
//   start_replay  begin a replay pass (pulse)
//   resend        pricing engine requests a fresh pass (pulse)
//   rd_valid      rd_data holds a replayed sample
//   rd_data       replayed sample (W bits), holds its value while rd_valid=0
//   rd_last_day   sample is day DAY-1 of its path
//   rd_last       sample is the final sample of the pass
//   full          buffer holds NPATH*DAY samples
//   pass_cnt      started passes, saturating at 255
// -----------------------------------------------------------------------------
module path_replay_ctrl #(
  parameter int DAY   = 8,
  parameter int NPATH = 256,
  parameter int W     = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         wr_valid,
  input  logic [W-1:0] wr_data,
  input  logic         start_replay,
  input  logic         resend,
  output logic         rd_valid,
  output logic [W-1:0] rd_data,
  output logic         rd_last_day,
  output logic         rd_last,
  output logic         full,
  output logic [7:0]   pass_cnt
);

  localparam int DEPTH = NPATH * DAY;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DW    = (DAY > 1) ? $clog2(DAY) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [DW-1:0] LAST_DAY  = DW'(DAY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_FULL,
    S_REPLAY,
    S_WAIT
  } state_t;

  state_t        state, state_next;
  logic [AW-1:0] wr_cnt;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_day;   // day index of the sample at rd_addr
  logic          do_write;
  logic          do_issue;
  logic          do_restart;

  logic [W-1:0]  mem [DEPTH];

  // Next-state and per-cycle control strobes. clear outranks everything but
  // reset, so none of the strobes fire on a clear cycle (a coincident sample
  // is dropped).
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_next = state;
    do_write   = 1'b0;
    do_issue   = 1'b0;
    do_restart = 1'b0;
    if (clear) begin
      state_next = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE, S_FILL: begin
          // wr_cnt is 0 in IDLE, so the first sample lands at address 0.
          if (wr_valid) begin
            do_write   = 1'b1;
            state_next = (wr_cnt == LAST_ADDR) ? S_FULL : S_FILL;
          end
        end
        S_FULL: begin
          if (start_replay) begin
            do_restart = 1'b1;
            state_next = S_REPLAY;
          end
        end
        S_REPLAY: begin
          // A restart replaces this cycle's read, which produces the bubble.
          if (start_replay || resend) begin
            do_restart = 1'b1;
          end else begin
            do_issue = 1'b1;
            if (rd_addr == LAST_ADDR) state_next = S_WAIT;
          end
        end
        S_WAIT: begin
          if (start_replay || resend) begin
            do_restart = 1'b1;
            state_next = S_REPLAY;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // NOTE: the sample buffer has no reset; its contents are only read after a
  // complete fill, so clearing it would cost a long reset sequence for nothing.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_cnt] <= wr_data;
  end

  // Counters and the registered read port. Flags are registered alongside
  // rd_data so all four read outputs stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt      <= '0;
      rd_addr     <= '0;
      rd_day      <= '0;
      full        <= 1'b0;
      pass_cnt    <= '0;
      rd_valid    <= 1'b0;
      rd_last_day <= 1'b0;
      rd_last     <= 1'b0;
      rd_data     <= '0;
    end else if (clear) begin
      wr_cnt      <= '0;
      rd_addr     <= '0;
      rd_day      <= '0;
      full        <= 1'b0;
      pass_cnt    <= '0;
      rd_valid    <= 1'b0;
      rd_last_day <= 1'b0;
      rd_last     <= 1'b0;
    end else begin
      rd_valid    <= do_issue;
      rd_last_day <= do_issue && (rd_day == LAST_DAY);
      rd_last     <= do_issue && (rd_addr == LAST_ADDR);

      if (do_write) begin
        wr_cnt <= (wr_cnt == LAST_ADDR) ? '0 : wr_cnt + AW'(1);
        if (wr_cnt == LAST_ADDR) full <= 1'b1;
      end

      if (do_restart) begin
        rd_addr <= '0;
        rd_day  <= '0;
        if (pass_cnt != 8'hFF) pass_cnt <= pass_cnt + 8'd1;
      end else if (do_issue) begin
        rd_data <= mem[rd_addr];
        rd_addr <= (rd_addr == LAST_ADDR) ? '0 : rd_addr + AW'(1);
        rd_day  <= (rd_day == LAST_DAY) ? '0 : rd_day + DW'(1);
      end
    end
  end

endmodule

// File: tb/tb_path_replay_ctrl.sv
// -----------------------------------------------------------------------------
// tb_path_replay_ctrl
//   Self-checking bench for path_replay_ctrl. Expected replay samples are
//   queued when a pass is requested and compared by a negedge monitor as the
//   DUT presents them; control-level results are checked inline.
// -----------------------------------------------------------------------------
module tb_path_replay_ctrl;

  localparam int DAY   = 8;
  localparam int NPATH = 256;
  localparam int W     = 12;
  localparam int DEPTH = NPATH * DAY;

  typedef struct {
    logic [W-1:0] data;
    logic         last_day;
    logic         last;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clear = 1'b0;
  logic         wr_valid = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic         start_replay = 1'b0;
  logic         resend = 1'b0;
  logic         rd_valid;
  logic [W-1:0] rd_data;
  logic         rd_last_day;
  logic         rd_last;
  logic         full;
  logic [7:0]   pass_cnt;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_pass = 0;

  path_replay_ctrl #(.DAY(DAY), .NPATH(NPATH), .W(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .wr_valid     (wr_valid),
    .wr_data      (wr_data),
    .start_replay (start_replay),
    .resend       (resend),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .rd_last_day  (rd_last_day),
    .rd_last      (rd_last),
    .full         (full),
    .pass_cnt     (pass_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  // Scoreboard monitor: every valid output must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n && rd_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_rd_valid", 32'(rd_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rd_data", 32'(rd_data), 32'(e.data));
        check("rd_last_day", 32'(rd_last_day), 32'(e.last_day));
        check("rd_last", 32'(rd_last), 32'(e.last));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] sample_val(input int a, input bit inv);
    logic [W-1:0] v;
    v = W'(a);
    return inv ? ~v : v;
  endfunction

  task automatic push_pass(input bit inv, input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.data     = sample_val(i, inv);
      e.last_day = ((i % DAY) == DAY - 1);
      e.last     = (i == DEPTH - 1);
      sb.push_back(e);
    end
  endtask

  // Requests a restart; the edge that samples it is the reference edge E.
  task automatic restart(input logic sr, input logic rs);
    start_replay = sr;
    resend       = rs;
    tick();
    start_replay = 1'b0;
    resend       = 1'b0;
    if (exp_pass < 255) exp_pass++;
  endtask

  // Fills the buffer with random gaps, optionally pulsing the replay controls
  // in the gaps (they must be ignored while filling).
  task automatic fill(input bit inv, input bit noise);
    for (int a = 0; a < DEPTH; a++) begin
      int gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        if (noise) begin
          start_replay = 1'($urandom_range(0, 1));
          resend       = 1'($urandom_range(0, 1));
        end
        tick();
        start_replay = 1'b0;
        resend       = 1'b0;
      end
      if (a == DEPTH - 1) check("full_before_last_write", 32'(full), 32'd0);
      wr_valid = 1'b1;
      wr_data  = sample_val(a, inv);
      tick();
      wr_valid = 1'b0;
    end
    check("full_after_last_write", 32'(full), 32'd1);
  endtask

  // Waits (bounded) for the queued pass to drain; called right after E.
  // Samples 0..DEPTH-1 appear after E+1..E+DEPTH, so the queue is empty when
  // probed after edge E+DEPTH+1.
  task automatic drain(input string tag, input bit inv);
    int cyc = 0;
    while (sb.size() != 0 && cyc < DEPTH + 16) begin
      @(posedge clk);
      #2;
      cyc++;
    end
    check(tag, 32'(cyc), 32'(DEPTH + 1));
    check("rd_valid_after_pass", 32'(rd_valid), 32'd0);
    check("rd_data_hold", 32'(rd_data), 32'(sample_val(DEPTH - 1, inv)));
    check("pass_cnt", 32'(pass_cnt), 32'(exp_pass));
  endtask

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset_rd_valid", 32'(rd_valid), 32'd0);
    check("reset_full", 32'(full), 32'd0);
    check("reset_pass_cnt", 32'(pass_cnt), 32'd0);
    check("reset_rd_data", 32'(rd_data), 32'd0);
    rst_n = 1'b1;
    tick();

    // Fill with wr_data=addr; replay controls during FILL are ignored.
    fill(1'b0, 1'b1);
    check("pass_cnt_after_fill", 32'(pass_cnt), 32'd0);

    // Writes in FULL must not alter the contents.
    wr_valid = 1'b1;
    wr_data  = 12'hABC;
    repeat (8) tick();
    wr_valid = 1'b0;
    check("full_held", 32'(full), 32'd1);

    // First full pass.
    restart(1'b1, 1'b0);
    push_pass(1'b0, DEPTH);
    drain("pass1_cycles", 1'b0);

    // resend in WAIT starts a pass; resend while sample 500 is out aborts it.
    restart(1'b0, 1'b1);
    push_pass(1'b0, 501);
    repeat (501) tick();
    restart(1'b0, 1'b1);
    check("resend_bubble", 32'(rd_valid), 32'd0);
    push_pass(1'b0, DEPTH);
    drain("resend_pass_cycles", 1'b0);

    // Both controls together in WAIT: one restart only.
    restart(1'b1, 1'b1);
    push_pass(1'b0, DEPTH);
    drain("dual_ctrl_cycles", 1'b0);

    // Asynchronous reset mid-pass: outputs drop without waiting for an edge.
    restart(1'b1, 1'b0);
    push_pass(1'b0, 100);
    repeat (100) tick();
    rst_n = 1'b0;
    #1;
    check("async_rst_rd_valid", 32'(rd_valid), 32'd0);
    check("async_rst_full", 32'(full), 32'd0);
    check("async_rst_pass_cnt", 32'(pass_cnt), 32'd0);
    check("async_rst_rd_last_day", 32'(rd_last_day), 32'd0);
    sb.delete();
    exp_pass = 0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Clear mid-FILL (coincident sample dropped), then refill with ~addr.
    for (int a = 0; a < 500; a++) begin
      wr_valid = 1'b1;
      wr_data  = 12'h555;
      tick();
    end
    check("partial_fill_full", 32'(full), 32'd0);
    clear   = 1'b1;
    wr_data = 12'h3C3;
    tick();
    clear    = 1'b0;
    wr_valid = 1'b0;
    check("clear_full", 32'(full), 32'd0);
    fill(1'b1, 1'b0);
    restart(1'b1, 1'b0);
    push_pass(1'b1, DEPTH);
    drain("refill_pass_cycles", 1'b1);

    // Restart on every cycle: no output, pass_cnt saturates at 255.
    resend = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (exp_pass < 255) exp_pass++;
      if (i == 100) begin
        check("held_resend_rd_valid", 32'(rd_valid), 32'd0);
        check("pass_cnt_climbing", 32'(pass_cnt), 32'(exp_pass));
      end
    end
    resend = 1'b0;
    check("pass_cnt_saturated", 32'(pass_cnt), 32'd255);
    push_pass(1'b1, DEPTH);
    drain("post_sat_pass_cycles", 1'b1);

    // clear during REPLAY: rd_valid low from the next cycle, full dropped.
    restart(1'b1, 1'b0);
    push_pass(1'b1, 10);
    repeat (10) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_replay_rd_valid", 32'(rd_valid), 32'd0);
    check("clear_replay_full", 32'(full), 32'd0);
    check("clear_replay_queue", 32'(sb.size()), 32'd0);
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
